// File: rtl/bidir_serializer.sv
// rtl/bidir_serializer.sv - parallel-to-serial front end for a bidirectional shift register
// Emits LSB-first (dir=0) or MSB-first (dir=1) so the downstream register ends holding the word.
module bidir_serializer #(
  parameter int N   = 4,
  parameter int GAP = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_dir,
  output logic         serial_out,
  output logic         dir,
  output logic         shift_en,
  output logic         frame_last,
  output logic         frame_done,
  output logic         busy
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP_ST} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  shreg_q, shreg_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]    gap_cnt_q, gap_cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          serial_out_q, serial_out_d;
  logic          dir_q, dir_d;
  logic          shift_en_q, shift_en_d;
  logic          frame_last_q, frame_last_d;
  logic          frame_done_q, frame_done_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    in_ready_d   = in_ready_q;
    serial_out_d = serial_out_q;
    dir_d        = dir_q;
    shift_en_d   = shift_en_q;
    frame_last_d = frame_last_q;
    frame_done_d = 1'b0;
    busy_d       = busy_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          // Bit 0 goes out straight from the input; the buffer keeps the remaining bits.
          serial_out_d = in_dir ? in_data[N-1] : in_data[0];
          shreg_d      = in_dir ? (in_data << 1) : (in_data >> 1);
          dir_d        = in_dir;
          bit_cnt_d    = '0;
          shift_en_d   = 1'b1;
          frame_last_d = 1'b0;
          busy_d       = 1'b1;
          in_ready_d   = 1'b0;
          state_d      = SHIFT;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      SHIFT: begin
        if (bit_cnt_q == CW'(N - 1)) begin
          serial_out_d = 1'b0;
          shift_en_d   = 1'b0;
          frame_last_d = 1'b0;
          frame_done_d = 1'b1;
          bit_cnt_d    = '0;
          if (GAP == 0) begin
            state_d    = IDLE;
            busy_d     = 1'b0;
            in_ready_d = 1'b1;
          end else begin
            state_d   = GAP_ST;
            gap_cnt_d = 8'(GAP - 1);
          end
        end else begin
          serial_out_d = dir_q ? shreg_q[N-1] : shreg_q[0];
          shreg_d      = dir_q ? (shreg_q << 1) : (shreg_q >> 1);
          bit_cnt_d    = bit_cnt_q + 1'b1;
          frame_last_d = (bit_cnt_q == CW'(N - 2));
        end
      end
      GAP_ST: begin
        if (gap_cnt_q == 8'd0) begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          in_ready_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: begin
        state_d    = IDLE;
        busy_d     = 1'b0;
        shift_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      in_ready_q   <= 1'b0;
      serial_out_q <= 1'b0;
      dir_q        <= 1'b0;
      shift_en_q   <= 1'b0;
      frame_last_q <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      in_ready_q   <= in_ready_d;
      serial_out_q <= serial_out_d;
      dir_q        <= dir_d;
      shift_en_q   <= shift_en_d;
      frame_last_q <= frame_last_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign serial_out = serial_out_q;
  assign dir        = dir_q;
  assign shift_en   = shift_en_q;
  assign frame_last = frame_last_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_bidir_serializer.sv
// tb/tb_bidir_serializer.sv - directed bench for bidir_serializer with GAP=0 and GAP=2 instances
// A behavioural downstream shift register per instance checks word reconstruction.
module tb_bidir_serializer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       v0 = 1'b0, dir0 = 1'b0;
  logic [3:0] d0 = 4'h0;
  logic       rdy0, so0, dro0, sh0, fl0, fd0, bz0;
  logic       v2 = 1'b0, dir2 = 1'b0;
  logic [3:0] d2 = 4'h0;
  logic       rdy2, so2, dro2, sh2, fl2, fd2, bz2;
  logic [3:0] q0 = 4'h0, q2 = 4'h0;

  int n_assert = 0;
  int n_fail   = 0;

  bidir_serializer #(.N(4), .GAP(0)) u0 (
    .clk(clk), .reset(reset), .in_valid(v0), .in_ready(rdy0), .in_data(d0), .in_dir(dir0),
    .serial_out(so0), .dir(dro0), .shift_en(sh0), .frame_last(fl0), .frame_done(fd0), .busy(bz0));

  bidir_serializer #(.N(4), .GAP(2)) u2 (
    .clk(clk), .reset(reset), .in_valid(v2), .in_ready(rdy2), .in_data(d2), .in_dir(dir2),
    .serial_out(so2), .dir(dro2), .shift_en(sh2), .frame_last(fl2), .frame_done(fd2), .busy(bz2));

  // Downstream bidirectional shift registers: dir=0 shifts right, dir=1 shifts left.
  always @(posedge clk) begin
    if (sh0) q0 <= dro0 ? {q0[2:0], so0} : {so0, q0[3:1]};
    if (sh2) q2 <= dro2 ? {q2[2:0], so2} : {so2, q2[3:1]};
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller has presented a word on u0; the next posedge accepts it.
  task automatic frame0(input string tag, input logic [3:0] data, input logic d,
                        input logic [3:0] seq, input bit hold, input logic [3:0] nxt);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (!hold) v0 = 1'b0;
      if (k == 1) begin
        d0   = ~d0;
        dir0 = ~dir0;
      end
      chk({tag, "_bit"}, {7'b0, so0}, {7'b0, seq[k]});
      chk({tag, "_shen"}, {7'b0, sh0}, 8'd1);
      chk({tag, "_last"}, {7'b0, fl0}, (k == 3) ? 8'd1 : 8'd0);
      chk({tag, "_dir"}, {7'b0, dro0}, {7'b0, d});
      chk({tag, "_rdy"}, {7'b0, rdy0}, 8'd0);
      chk({tag, "_busy"}, {7'b0, bz0}, 8'd1);
      chk({tag, "_fdlow"}, {7'b0, fd0}, 8'd0);
    end
    @(negedge clk);
    chk({tag, "_done"}, {7'b0, fd0}, 8'd1);
    chk({tag, "_q"}, {4'b0, q0}, {4'b0, data});
    chk({tag, "_shen_off"}, {7'b0, sh0}, 8'd0);
    chk({tag, "_rdy_back"}, {7'b0, rdy0}, 8'd1);
    chk({tag, "_busy_off"}, {7'b0, bz0}, 8'd0);
    d0   = nxt;
    dir0 = d;
  endtask

  initial begin
    // T1 reset
    @(negedge clk);
    chk("t1_rdy", {7'b0, rdy0}, 8'd0);
    chk("t1_shen", {7'b0, sh0}, 8'd0);
    chk("t1_so", {7'b0, so0}, 8'd0);
    chk("t1_dir", {7'b0, dro0}, 8'd0);
    chk("t1_busy", {7'b0, bz0}, 8'd0);
    chk("t1_rdy2", {7'b0, rdy2}, 8'd0);
    reset = 1'b0;
    #1 chk("t1_rdy_held", {7'b0, rdy0}, 8'd0);
    @(negedge clk);
    chk("t1_rdy_up", {7'b0, rdy0}, 8'd1);
    chk("t1_rdy2_up", {7'b0, rdy2}, 8'd1);

    // T2 LSB first
    v0 = 1'b1; d0 = 4'b1011; dir0 = 1'b0;
    frame0("t2", 4'b1011, 1'b0, 4'b1011, 1'b0, 4'h0);

    // T3 MSB first
    v0 = 1'b1; d0 = 4'b1000; dir0 = 1'b1;
    frame0("t3", 4'b1000, 1'b1, 4'b0001, 1'b0, 4'h0);
    chk("t3_dir_hold", {7'b0, dro0}, 8'd1);

    // T4 valid held, back-to-back
    v0 = 1'b1; d0 = 4'hA; dir0 = 1'b0;
    frame0("t4a", 4'hA, 1'b0, 4'b1010, 1'b1, 4'h5);
    frame0("t4b", 4'h5, 1'b0, 4'b0101, 1'b0, 4'h0);

    // T5 reset mid-frame
    v0 = 1'b1; d0 = 4'hF; dir0 = 1'b0;
    @(negedge clk);
    v0 = 1'b0;
    chk("t5_bit0", {7'b0, so0}, 8'd1);
    @(negedge clk);
    chk("t5_bit1", {7'b0, so0}, 8'd1);
    reset = 1'b1;
    #1;
    chk("t5_so", {7'b0, so0}, 8'd0);
    chk("t5_shen", {7'b0, sh0}, 8'd0);
    chk("t5_busy", {7'b0, bz0}, 8'd0);
    chk("t5_rdy", {7'b0, rdy0}, 8'd0);
    chk("t5_dir", {7'b0, dro0}, 8'd0);
    @(negedge clk);
    chk("t5_nodone", {7'b0, fd0}, 8'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_nodone2", {7'b0, fd0}, 8'd0);
    chk("t5_rdy_up", {7'b0, rdy0}, 8'd1);
    v0 = 1'b1; d0 = 4'h3; dir0 = 1'b0;
    frame0("t5", 4'h3, 1'b0, 4'b0011, 1'b0, 4'h0);

    // T6 GAP=2 back-to-back on u2
    v2 = 1'b1; d2 = 4'h6; dir2 = 1'b1;
    for (int w = 0; w < 2; w++) begin
      logic [3:0] seq;
      logic [3:0] word;
      word = (w == 0) ? 4'h6 : 4'h9;
      seq  = (w == 0) ? 4'b0110 : 4'b1001;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (w == 1) v2 = 1'b0;
        chk("t6_bit", {7'b0, so2}, {7'b0, seq[k]});
        chk("t6_last", {7'b0, fl2}, (k == 3) ? 8'd1 : 8'd0);
        chk("t6_rdy", {7'b0, rdy2}, 8'd0);
      end
      @(negedge clk);
      chk("t6_done", {7'b0, fd2}, 8'd1);
      chk("t6_q", {4'b0, q2}, {4'b0, word});
      chk("t6_gap_rdy0", {7'b0, rdy2}, 8'd0);
      chk("t6_gap_busy", {7'b0, bz2}, 8'd1);
      @(negedge clk);
      chk("t6_gap_rdy1", {7'b0, rdy2}, 8'd0);
      chk("t6_done_pulse", {7'b0, fd2}, 8'd0);
      chk("t6_gap_shen", {7'b0, sh2}, 8'd0);
      @(negedge clk);
      chk("t6_rdy_up", {7'b0, rdy2}, 8'd1);
      chk("t6_busy_off", {7'b0, bz2}, 8'd0);
      d2 = 4'h9;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
